// File: rtl/elevator_ctrl_nfloor_if.sv
// Bundle between call-button decode (master) and the elevator car controller (slave).
// The master drives call requests; the slave returns car position and door/motion status.
interface elevator_ctrl_nfloor_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int IDX_W = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] req_vec;
  logic [NUM_FLOORS-1:0] cur_floor;
  logic [IDX_W-1:0]      cur_floor_idx;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;

  modport master (
    output req_vec,
    input  cur_floor, cur_floor_idx, pending, dir_up, moving, door_open
  );

  modport slave (
    input  req_vec,
    output cur_floor, cur_floor_idx, pending, dir_up, moving, door_open
  );
endinterface

// File: rtl/elevator_ctrl_nfloor.sv
// N-floor elevator car controller: latched requests, SCAN direction scheduling,
// prescaled move ticks and a timed door-open phase. All outputs are registered.
module elevator_ctrl_nfloor #(
  parameter int NUM_FLOORS = 8,
  parameter int TICK_DIV   = 32768,
  parameter int DOOR_TICKS = 3
) (
  input logic clk,
  input logic rst,
  elevator_ctrl_nfloor_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_FLOORS);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t                state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [DOOR_W-1:0]     door_cnt_q, door_cnt_d;
  logic [NUM_FLOORS-1:0] cur_floor_q, cur_floor_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  dir_up_q, dir_up_d;
  logic                  moving_q, moving_d;
  logic                  door_open_q, door_open_d;

  logic                  tick;
  logic [NUM_FLOORS-1:0] req_eff;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] up_floor;
  logic [NUM_FLOORS-1:0] dn_floor;
  logic                  above;
  logic                  below;

  function automatic logic [NUM_FLOORS-1:0] above_mask(input int k);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > k);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input int k);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < k);
    return m;
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    req_eff    = pending_q | bus.req_vec;
    above      = |(req_eff & above_mask(int'(idx_q)));
    below      = |(req_eff & below_mask(int'(idx_q)));
    up_floor   = cur_floor_q << 1;
    dn_floor   = cur_floor_q >> 1;

    state_d     = state_q;
    door_cnt_d  = door_cnt_q;
    cur_floor_d = cur_floor_q;
    idx_d       = idx_q;
    dir_up_d    = dir_up_q;
    clear_mask  = '0;

    case (state_q)
      IDLE: begin
        if (|(req_eff & cur_floor_q)) begin
          state_d    = DOOR_OPEN;
          clear_mask = cur_floor_q;
          door_cnt_d = '0;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end

      MOVE_UP: begin
        // Top-floor guard should never trigger; it keeps the shift from falling off the end.
        if (cur_floor_q[NUM_FLOORS-1]) begin
          state_d = IDLE;
        end else if (tick) begin
          cur_floor_d = up_floor;
          idx_d       = idx_q + 1'b1;
          if (|(req_eff & up_floor)) begin
            state_d    = DOOR_OPEN;
            clear_mask = up_floor;
            door_cnt_d = '0;
          end else if (!(|(req_eff & above_mask(int'(idx_q) + 1)))) begin
            state_d = IDLE;
          end
        end
      end

      MOVE_DOWN: begin
        if (cur_floor_q[0]) begin
          state_d = IDLE;
        end else if (tick) begin
          cur_floor_d = dn_floor;
          idx_d       = idx_q - 1'b1;
          if (|(req_eff & dn_floor)) begin
            state_d    = DOOR_OPEN;
            clear_mask = dn_floor;
            door_cnt_d = '0;
          end else if (!(|(req_eff & below_mask(int'(idx_q) - 1)))) begin
            state_d = IDLE;
          end
        end
      end

      DOOR_OPEN: begin
        // Calls for this floor while the door is open are absorbed without extending the timer.
        clear_mask = cur_floor_q;
        if (tick) begin
          if (door_cnt_q == DOOR_W'(DOOR_TICKS - 1)) begin
            state_d    = IDLE;
            door_cnt_d = '0;
          end else begin
            door_cnt_d = door_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    pending_d   = req_eff & ~clear_mask;
    moving_d    = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    door_open_d = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      door_cnt_q  <= '0;
      cur_floor_q <= NUM_FLOORS'(1);
      idx_q       <= '0;
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      door_cnt_q  <= door_cnt_d;
      cur_floor_q <= cur_floor_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign bus.cur_floor     = cur_floor_q;
  assign bus.cur_floor_idx = idx_q;
  assign bus.pending       = pending_q;
  assign bus.dir_up        = dir_up_q;
  assign bus.moving        = moving_q;
  assign bus.door_open     = door_open_q;
endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// Directed bench for elevator_ctrl_nfloor with NUM_FLOORS=8, TICK_DIV=4, DOOR_TICKS=2.
// Move ticks are predicted from a bench-side cycle count since reset release.
module tb_elevator_ctrl_nfloor;
  localparam int NF = 8;
  localparam int TD = 4;
  localparam int DT = 2;

  logic clk;
  logic rst;
  int   vec_count;
  int   miss_count;
  int   cyc;

  localparam logic [31:0] RESET_STATUS = {10'd0, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};

  elevator_ctrl_nfloor_if #(.NUM_FLOORS(NF)) bus ();

  elevator_ctrl_nfloor #(
    .NUM_FLOORS(NF),
    .TICK_DIV  (TD),
    .DOOR_TICKS(DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the DUT ticks on edges where this becomes a multiple of TD.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [31:0] status();
    return {10'd0, bus.cur_floor, bus.cur_floor_idx, bus.pending,
            bus.dir_up, bus.moving, bus.door_open};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NF-1:0] req);
    bus.req_vec = req;
    stepCycle();
    bus.req_vec = '0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bus.req_vec = '0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  task automatic waitDoorOpen(input string tag, input int budget);
    int n = 0;
    while (!bus.door_open && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {31'd0, bus.door_open}, 32'd1);
  endtask

  task automatic waitDoorClose(input string tag, input int budget, output int n);
    n = 0;
    while (bus.door_open && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {31'd0, bus.door_open}, 32'd0);
  endtask

  task automatic waitIdx(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (bus.cur_floor_idx != target && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {29'd0, bus.cur_floor_idx}, {29'd0, target});
  endtask

  initial begin
    int n;
    int e;
    int exp_close;
    logic [2:0] prev;

    vec_count  = 0;
    miss_count = 0;
    rst = 1'b1;
    bus.req_vec = '0;

    // 1: reset state held with no requests
    applyReset();
    checkOutput("t1_reset", status(), RESET_STATUS);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      checkOutput("t1_hold", status(), RESET_STATUS);
    end

    // 2: single request for floor 5
    applyStimulus(8'h20);
    checkOutput("t2_pending", {24'd0, bus.pending}, 32'h20);
    checkOutput("t2_moving", {30'd0, bus.moving, bus.dir_up}, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      prev = bus.cur_floor_idx;
      n = 0;
      while (bus.cur_floor_idx == prev && n < 10) begin
        stepCycle();
        n++;
      end
      checkOutput("t2_idx", {29'd0, bus.cur_floor_idx}, k);
      checkOutput("t2_on_tick", cyc % TD, 0);
    end
    checkOutput("t2_arrive", status(), {10'd0, 8'h20, 3'd5, 8'h00, 1'b1, 1'b0, 1'b1});
    waitDoorClose("t2_close", 20, n);
    checkOutput("t2_door_len", n, 8);
    checkOutput("t2_idle", status(), {10'd0, 8'h20, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0});

    // 3: SCAN - stop at 4 and 6 on the way up, then reverse to 1
    applyReset();
    applyStimulus(8'h40);
    waitIdx("t3_reach3", 3'd3, 40);
    checkOutput("t3_moving3", {31'd0, bus.moving}, 32'd1);
    applyStimulus(8'h12);
    checkOutput("t3_latch", {24'd0, bus.pending}, 32'h52);
    waitDoorOpen("t3_door4", 40);
    checkOutput("t3_stop4", {21'd0, bus.cur_floor_idx, bus.pending}, {21'd0, 3'd4, 8'h42});
    checkOutput("t3_dir4", {31'd0, bus.dir_up}, 32'd1);
    waitDoorClose("t3_close4", 20, n);
    waitDoorOpen("t3_door6", 40);
    checkOutput("t3_stop6", {21'd0, bus.cur_floor_idx, bus.pending}, {21'd0, 3'd6, 8'h02});
    waitDoorClose("t3_close6", 20, n);
    stepCycle();
    checkOutput("t3_reverse", {30'd0, bus.moving, bus.dir_up}, 32'd2);
    waitDoorOpen("t3_door1", 60);
    checkOutput("t3_stop1", status(), {10'd0, 8'h02, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1});
    waitDoorClose("t3_close1", 20, n);

    // 4: request at the current floor, repeat absorbed while door open
    applyStimulus(8'h04);
    waitDoorOpen("t4_door2a", 20);
    checkOutput("t4_floor2", {29'd0, bus.cur_floor_idx}, 32'd2);
    waitDoorClose("t4_close2a", 20, n);
    stepCycle();
    applyStimulus(8'h04);
    checkOutput("t4_open_now", status(), {10'd0, 8'h04, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1});
    e = cyc;
    exp_close = (e / TD + 1) * TD + TD;
    stepCycle();
    applyStimulus(8'h04);
    checkOutput("t4_absorb", {23'd0, bus.pending, bus.door_open}, 32'd1);
    waitDoorClose("t4_close2b", 20, n);
    checkOutput("t4_close_cyc", cyc, exp_close);
    checkOutput("t4_no_move", {21'd0, bus.cur_floor_idx, bus.cur_floor}, {21'd0, 3'd2, 8'h04});

    // 5: top boundary, then all the way back down
    applyReset();
    applyStimulus(8'h80);
    waitDoorOpen("t5_door7", 60);
    checkOutput("t5_top", {21'd0, bus.cur_floor_idx, bus.cur_floor}, {21'd0, 3'd7, 8'h80});
    waitDoorClose("t5_close7", 20, n);
    for (int i = 0; i < 8; i++) stepCycle();
    checkOutput("t5_stay_top", status(), {10'd0, 8'h80, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0});
    applyStimulus(8'h01);
    checkOutput("t5_down", {30'd0, bus.moving, bus.dir_up}, 32'd2);
    waitDoorOpen("t5_door0", 60);
    checkOutput("t5_ground", status(), {10'd0, 8'h01, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    waitDoorClose("t5_close0", 20, n);

    // 6: reset while moving between floors 2 and 3
    applyReset();
    applyStimulus(8'h20);
    waitIdx("t6_reach2", 3'd2, 20);
    applyStimulus(8'h08);
    checkOutput("t6_mid", {20'd0, bus.cur_floor_idx, bus.pending, bus.moving},
                {20'd0, 3'd2, 8'h28, 1'b1});
    rst = 1'b1;
    stepCycle();
    checkOutput("t6_reset", status(), RESET_STATUS);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("t6_hold", status(), RESET_STATUS);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule
